// File: rtl/skein_out_pkg.sv
// Shared sizes, state encoding and word-extraction helper for the result word sequencer.
// RESULT_SEQ_CHECKSUM_EN selects whether the ST_CHK state is reachable in the sequencer.
package skein_out_pkg;

    localparam int unsigned RESULT_WORDS = 16;
    localparam int unsigned WORD_IDX_W   = 4;
    localparam int unsigned REF_WORD_W   = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_CHK  = 2'd2
    } state_e;

    // Word k of a packed result vector at the reference word width.
    function automatic logic [REF_WORD_W-1:0] get_word(
        input logic [RESULT_WORDS*REF_WORD_W-1:0] vec,
        input logic [WORD_IDX_W-1:0]              k
    );
        return vec[32'(k)*REF_WORD_W +: REF_WORD_W];
    endfunction

endpackage

// File: rtl/result_word_mux.sv
// Combinational 16:1 word selector over a packed result vector.
module result_word_mux
    import skein_out_pkg::*;
#(
    parameter int unsigned WORD_W = 64
) (
    input  logic [RESULT_WORDS*WORD_W-1:0] vec,
    input  logic [WORD_IDX_W-1:0]          idx,
    output logic [WORD_W-1:0]              word
);

    assign word = vec[32'(idx)*WORD_W +: WORD_W];

endmodule

// File: rtl/result_word_sequencer.sv
// Latches a 16-word result and streams it one word per beat over valid/ready.
// Define RESULT_SEQ_CHECKSUM_EN to append an XOR-of-all-words beat after word 15.
module result_word_sequencer
    import skein_out_pkg::*;
#(
    parameter int unsigned WORD_W = 64
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           result_valid_i,
    output logic                           result_ready_o,
    input  logic [RESULT_WORDS*WORD_W-1:0] result_data_i,
    input  logic                           abort_i,
    output logic [WORD_IDX_W-1:0]          word_o,
    output logic                           word_valid_o,
    input  logic                           word_ready_i,
    output logic [WORD_W-1:0]              word_data_o,
    output logic                           last_o,
    output logic                           busy_o
);

    localparam logic [WORD_IDX_W-1:0] LAST_IDX = WORD_IDX_W'(RESULT_WORDS - 1);

    state_e                         state_q;
    logic [WORD_IDX_W-1:0]          idx_q;
    logic [WORD_IDX_W-1:0]          idx_nxt;
    logic [RESULT_WORDS*WORD_W-1:0] hold_q;
    logic [RESULT_WORDS*WORD_W-1:0] mux_vec;
    logic [WORD_W-1:0]              mux_word;
    logic [WORD_W-1:0]              data_q;
    logic                           valid_q;
    logic                           last_q;
`ifdef RESULT_SEQ_CHECKSUM_EN
    logic [WORD_W-1:0]              csum_q;
`endif

    // Select the word for the next beat so word_data_o can be registered.
    always_comb begin
        idx_nxt = '0;
        mux_vec = hold_q;
        if (state_q == ST_IDLE) begin
            mux_vec = result_data_i;
        end else begin
            idx_nxt = idx_q + 1'b1;
        end
    end

    result_word_mux #(
        .WORD_W (WORD_W)
    ) u_mux (
        .vec  (mux_vec),
        .idx  (idx_nxt),
        .word (mux_word)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
`ifdef RESULT_SEQ_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else if (abort_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (result_valid_i) begin
                        state_q <= ST_SEND;
                        hold_q  <= result_data_i;
                        idx_q   <= idx_nxt;
                        data_q  <= mux_word;
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
`ifdef RESULT_SEQ_CHECKSUM_EN
                        csum_q  <= '0;
`endif
                    end
                end
                ST_SEND: begin
                    if (word_ready_i) begin
`ifdef RESULT_SEQ_CHECKSUM_EN
                        csum_q <= csum_q ^ data_q;
`endif
                        if (idx_q == LAST_IDX) begin
                            idx_q <= '0;
`ifdef RESULT_SEQ_CHECKSUM_EN
                            state_q <= ST_CHK;
                            data_q  <= csum_q ^ data_q;
                            last_q  <= 1'b1;
`else
                            state_q <= ST_IDLE;
                            data_q  <= '0;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
`endif
                        end else begin
                            idx_q  <= idx_nxt;
                            data_q <= mux_word;
`ifdef RESULT_SEQ_CHECKSUM_EN
                            last_q <= 1'b0;
`else
                            last_q <= (idx_nxt == LAST_IDX);
`endif
                        end
                    end
                end
`ifdef RESULT_SEQ_CHECKSUM_EN
                ST_CHK: begin
                    if (word_ready_i) begin
                        state_q <= ST_IDLE;
                        data_q  <= '0;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                    idx_q   <= '0;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign result_ready_o = (state_q == ST_IDLE);
    assign busy_o         = (state_q != ST_IDLE);
    assign word_o         = idx_q;
    assign word_valid_o   = valid_q;
    assign word_data_o    = data_q;
    assign last_o         = last_q;

endmodule

// File: tb/tb_result_word_sequencer.sv
// Directed and randomized bench for result_word_sequencer against a beat-list reference model.
// Honours RESULT_SEQ_CHECKSUM_EN the same way the design does.
module tb_result_word_sequencer;

    localparam int unsigned W = 64;
`ifdef RESULT_SEQ_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    typedef logic [W-1:0] words_t [16];

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           result_valid = 1'b0;
    logic           result_ready;
    logic [16*W-1:0] result_data = '0;
    logic           abort = 1'b0;
    logic [3:0]     word;
    logic           word_valid;
    logic           word_ready = 1'b0;
    logic [W-1:0]   word_data;
    logic           last;
    logic           busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    result_word_sequencer #(
        .WORD_W (W)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .result_valid_i (result_valid),
        .result_ready_o (result_ready),
        .result_data_i  (result_data),
        .abort_i        (abort),
        .word_o         (word),
        .word_valid_o   (word_valid),
        .word_ready_i   (word_ready),
        .word_data_o    (word_data),
        .last_o         (last),
        .busy_o         (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 64'(word_valid), 64'd0);
        chk({tag, "_word"}, 64'(word), 64'd0);
        chk({tag, "_ready"}, 64'(result_ready), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_last"}, 64'(last), 64'd0);
    endtask

    // Called at a negedge in IDLE; returns at the negedge where the first beat is due.
    task automatic accept(input words_t w);
        chk("accept_ready", 64'(result_ready), 64'd1);
        for (int k = 0; k < 16; k++) result_data[k*W +: W] = w[k];
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
    endtask

    task automatic run_stream(input words_t w, input bit rand_rdy, input int stall_idx,
                              input int abort_idx, input int reset_idx);
        logic [W-1:0] exp_d [$];
        int           exp_w [$];
        bit           exp_l [$];
        logic [W-1:0] xs;
        int           b;
        int           cyc;
        int           stall_left;
        logic         rdy;
        xs = '0;
        for (int k = 0; k < 16; k++) begin
            exp_d.push_back(w[k]);
            exp_w.push_back(k);
            exp_l.push_back(k == 15 && !CS_EN);
            xs ^= w[k];
        end
        if (CS_EN) begin
            exp_d.push_back(xs);
            exp_w.push_back(0);
            exp_l.push_back(1'b1);
        end
        b = 0;
        cyc = 0;
        stall_left = 3;
        while (b < exp_d.size() && cyc < 400) begin
            rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (b < 16 && exp_w[b] == stall_idx && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end
            word_ready = rdy;
            chk("beat_valid", 64'(word_valid), 64'd1);
            chk("beat_word", 64'(word), 64'(exp_w[b]));
            chk("beat_data", word_data, exp_d[b]);
            chk("beat_last", 64'(last), 64'(exp_l[b]));
            chk("beat_rdy_low", 64'(result_ready), 64'd0);
            chk("beat_busy", 64'(busy), 64'd1);
            if (b < 16 && exp_w[b] == abort_idx) begin
                abort = 1'b1;
                word_ready = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk_idle("abort");
                return;
            end
            if (b < 16 && exp_w[b] == reset_idx) begin
                #2 rst_n = 1'b0;
                #1;
                chk_idle("async_rst");
                chk("async_rst_data", word_data, 64'd0);
                #1 rst_n = 1'b1;
                @(negedge clk);
                chk_idle("post_rst");
                return;
            end
            if (rdy) b++;
            @(negedge clk);
            cyc++;
        end
        chk("beats_done", 64'(b), 64'(exp_d.size()));
        if (!rand_rdy && stall_idx < 0) chk("throughput", 64'(cyc), 64'(exp_d.size()));
        if (!rand_rdy && stall_idx >= 0) chk("stall_cycles", 64'(cyc), 64'(exp_d.size() + 3));
        chk_idle("end");
    endtask

    words_t wa;
    words_t wb;

    initial begin
        // Reset values
        #2;
        chk_idle("reset");
        chk("reset_data", word_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: patterned result, full throughput
        for (int k = 0; k < 16; k++) wa[k] = 64'h1111_0000_0000_0000 * 64'(k) + 64'(k);
        accept(wa);
        run_stream(wa, 1'b0, -1, -1, -1);

        // 2: stall three cycles at word 5
        for (int k = 0; k < 16; k++) wa[k] = {$urandom, $urandom};
        accept(wa);
        run_stream(wa, 1'b0, 5, -1, -1);

        // 3: second result offered during streaming; held result must not change
        for (int k = 0; k < 16; k++) wa[k] = {$urandom, $urandom};
        for (int k = 0; k < 16; k++) wb[k] = {$urandom, $urandom};
        accept(wa);
        for (int k = 0; k < 16; k++) result_data[k*W +: W] = wb[k];
        result_valid = 1'b1;
        run_stream(wa, 1'b0, -1, -1, -1);
        @(negedge clk);
        result_valid = 1'b0;
        run_stream(wb, 1'b0, -1, -1, -1);

        // 4: abort on the beat transfer at word 9, then abort beating an accept
        for (int k = 0; k < 16; k++) wa[k] = {$urandom, $urandom};
        accept(wa);
        run_stream(wa, 1'b0, -1, 9, -1);
        result_valid = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        abort = 1'b0;
        chk_idle("abort_accept");

        // 5: async reset at word 12, then a fresh result from word 0
        for (int k = 0; k < 16; k++) wa[k] = {$urandom, $urandom};
        accept(wa);
        run_stream(wa, 1'b0, -1, -1, 12);
        for (int k = 0; k < 16; k++) wa[k] = {$urandom, $urandom};
        accept(wa);
        run_stream(wa, 1'b0, -1, -1, -1);

        // 6: identical words; checksum beat (if built) is zero
        for (int k = 0; k < 16; k++) wa[k] = 64'hA5A5_A5A5_A5A5_A5A5;
        accept(wa);
        run_stream(wa, 1'b0, -1, -1, -1);

        // Randomized data and backpressure
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 16; k++) wa[k] = {$urandom, $urandom};
            accept(wa);
            run_stream(wa, 1'b1, -1, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
